// File: rtl/id_ex_pipe.sv
// ID/EX stage register with load-use hazard detection, WB-to-ID write-through and flush/bubble insertion.
// Outputs are registered with one-cycle latency. hold freezes the stage. A load-use hazard inserts a bubble and drops PC/IF-ID writes.
module id_ex_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IF_ID_valid,
  input  logic [XLEN-1:0] ID_pc,
  input  logic [4:0]      ID_rs1,
  input  logic [4:0]      ID_rs2,
  input  logic [4:0]      ID_rd,
  input  logic            ID_use_rs1,
  input  logic            ID_use_rs2,
  input  logic [XLEN-1:0] ID_rs1_data,
  input  logic [XLEN-1:0] ID_rs2_data,
  input  logic [XLEN-1:0] ID_imm,
  input  logic            ID_RegWrite,
  input  logic            ID_MemRead,
  input  logic            ID_MemWrite,
  input  logic            ID_MemtoReg,
  input  logic            ID_ALUSrc,
  input  logic            ID_Branch,
  input  logic            ID_Jump,
  input  logic [3:0]      ID_ALUOp,
  input  logic            MEM_WB_RegWrite,
  input  logic [4:0]      MEM_WB_rd,
  input  logic [XLEN-1:0] WB_data,
  input  logic            EX_flush,
  input  logic            INT_flush,
  input  logic            hold,
  output logic            ID_EX_valid,
  output logic [XLEN-1:0] ID_EX_pc,
  output logic [4:0]      ID_EX_rs1,
  output logic [4:0]      ID_EX_rs2,
  output logic [4:0]      ID_EX_rd,
  output logic [XLEN-1:0] ID_EX_rs1_data,
  output logic [XLEN-1:0] ID_EX_rs2_data,
  output logic [XLEN-1:0] ID_EX_imm,
  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemtoReg,
  output logic            ID_EX_ALUSrc,
  output logic            ID_EX_Branch,
  output logic            ID_EX_Jump,
  output logic [3:0]      ID_EX_ALUOp,
  output logic            load_use_stall,
  output logic            PC_write,
  output logic            IF_ID_write,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [3:0]      alu_op;
  } stage_t;

  stage_t           stage_q, stage_d, capt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush, rs1_hit, rs2_hit, wt_rs1, wt_rs2;

  // Hazard path looks only at ID_EX state and ID inputs, never at hold.
  always_comb begin
    flush          = EX_flush | INT_flush;
    rs1_hit        = ID_use_rs1 && (stage_q.rd == ID_rs1);
    rs2_hit        = ID_use_rs2 && (stage_q.rd == ID_rs2);
    load_use_stall = stage_q.valid && stage_q.mem_read && (stage_q.rd != 5'd0) &&
                     IF_ID_valid && (rs1_hit || rs2_hit) && !flush;
    PC_write       = !(load_use_stall || hold);
    IF_ID_write    = !(load_use_stall || hold);
  end

  always_comb begin
    wt_rs1 = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == ID_rs1);
    wt_rs2 = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == ID_rs2);
    capt          = '0;
    capt.valid    = IF_ID_valid;
    capt.pc       = ID_pc;
    capt.rs1      = ID_rs1;
    capt.rs2      = ID_rs2;
    capt.rs1_data = wt_rs1 ? WB_data : ID_rs1_data;
    capt.rs2_data = wt_rs2 ? WB_data : ID_rs2_data;
    capt.imm      = ID_imm;
    capt.alu_op   = ID_ALUOp;
    // An empty decode slot must never write a register or look like a forwarding source.
    if (IF_ID_valid) begin
      capt.rd         = ID_rd;
      capt.reg_write  = ID_RegWrite;
      capt.mem_read   = ID_MemRead;
      capt.mem_write  = ID_MemWrite;
      capt.mem_to_reg = ID_MemtoReg;
      capt.alu_src    = ID_ALUSrc;
      capt.branch     = ID_Branch;
      capt.jump       = ID_Jump;
    end
  end

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush) begin
      stage_d = '0;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (load_use_stall) begin
      stage_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      stage_d = capt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ID_EX_valid    = stage_q.valid;
  assign ID_EX_pc       = stage_q.pc;
  assign ID_EX_rs1      = stage_q.rs1;
  assign ID_EX_rs2      = stage_q.rs2;
  assign ID_EX_rd       = stage_q.rd;
  assign ID_EX_rs1_data = stage_q.rs1_data;
  assign ID_EX_rs2_data = stage_q.rs2_data;
  assign ID_EX_imm      = stage_q.imm;
  assign ID_EX_RegWrite = stage_q.reg_write;
  assign ID_EX_MemRead  = stage_q.mem_read;
  assign ID_EX_MemWrite = stage_q.mem_write;
  assign ID_EX_MemtoReg = stage_q.mem_to_reg;
  assign ID_EX_ALUSrc   = stage_q.alu_src;
  assign ID_EX_Branch   = stage_q.branch;
  assign ID_EX_Jump     = stage_q.jump;
  assign ID_EX_ALUOp    = stage_q.alu_op;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: vector table plus hand sequences for reset, saturation and reset mid-stall.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_ID_valid;
  logic [31:0] ID_pc;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic        ID_use_rs1, ID_use_rs2;
  logic [31:0] ID_rs1_data, ID_rs2_data, ID_imm;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch, ID_Jump;
  logic [3:0]  ID_ALUOp;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] WB_data;
  logic        EX_flush, INT_flush, hold;

  logic        ID_EX_valid;
  logic [31:0] ID_EX_pc;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc;
  logic        ID_EX_Branch, ID_EX_Jump;
  logic [3:0]  ID_EX_ALUOp;
  logic        load_use_stall, PC_write, IF_ID_write;
  logic [15:0] stall_cnt;

  logic        s_valid, s_RegWrite, s_MemRead, s_MemWrite, s_MemtoReg, s_ALUSrc, s_Branch, s_Jump;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_ALUOp;
  logic        s_stall, s_PC_write, s_IF_ID_write;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .IF_ID_valid(IF_ID_valid), .ID_pc(ID_pc),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
    .ID_ALUOp(ID_ALUOp), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .WB_data(WB_data),
    .EX_flush(EX_flush), .INT_flush(INT_flush), .hold(hold),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_Jump(ID_EX_Jump), .ID_EX_ALUOp(ID_EX_ALUOp),
    .load_use_stall(load_use_stall), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_pipe #(.XLEN(32), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .IF_ID_valid(IF_ID_valid), .ID_pc(ID_pc),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
    .ID_ALUOp(ID_ALUOp), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .WB_data(WB_data),
    .EX_flush(EX_flush), .INT_flush(INT_flush), .hold(hold),
    .ID_EX_valid(s_valid), .ID_EX_pc(s_pc), .ID_EX_rs1(s_rs1), .ID_EX_rs2(s_rs2),
    .ID_EX_rd(s_rd), .ID_EX_rs1_data(s_rs1_data), .ID_EX_rs2_data(s_rs2_data),
    .ID_EX_imm(s_imm), .ID_EX_RegWrite(s_RegWrite), .ID_EX_MemRead(s_MemRead),
    .ID_EX_MemWrite(s_MemWrite), .ID_EX_MemtoReg(s_MemtoReg), .ID_EX_ALUSrc(s_ALUSrc),
    .ID_EX_Branch(s_Branch), .ID_EX_Jump(s_Jump), .ID_EX_ALUOp(s_ALUOp),
    .load_use_stall(s_stall), .PC_write(s_PC_write), .IF_ID_write(s_IF_ID_write),
    .stall_cnt(s_cnt)
  );

  typedef struct {
    logic        ifv, u1, u2, rw, mr, mwb_rw, exf, intf, hold;
    logic [4:0]  rs1, rs2, rd, mwb_rd;
    logic [31:0] d1, d2, imm, wb;
    logic        e_stall, e_pcw, e_valid, e_mr, e_rw;
    logic [4:0]  e_rd, e_rs1;
    logic [31:0] e_d1, e_d2, e_imm;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(
      input bit [31:0] ifv, rs1, u1, rs2, u2, rd, d1, d2, imm, rw, mr,
      input bit [31:0] mwb_rw, mwb_rd, wb, exf, intf, hld,
      input bit [31:0] e_stall, e_pcw, e_valid, e_rd, e_rs1, e_d1, e_d2, e_imm, e_mr, e_rw, e_cnt);
    vec_t v;
    v.ifv = ifv[0]; v.rs1 = rs1[4:0]; v.u1 = u1[0]; v.rs2 = rs2[4:0]; v.u2 = u2[0]; v.rd = rd[4:0];
    v.d1 = d1; v.d2 = d2; v.imm = imm; v.rw = rw[0]; v.mr = mr[0];
    v.mwb_rw = mwb_rw[0]; v.mwb_rd = mwb_rd[4:0]; v.wb = wb;
    v.exf = exf[0]; v.intf = intf[0]; v.hold = hld[0];
    v.e_stall = e_stall[0]; v.e_pcw = e_pcw[0]; v.e_valid = e_valid[0];
    v.e_rd = e_rd[4:0]; v.e_rs1 = e_rs1[4:0]; v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_imm = e_imm;
    v.e_mr = e_mr[0]; v.e_rw = e_rw[0]; v.e_cnt = e_cnt[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IF_ID_valid = v.ifv; ID_pc = 32'h0000_1000;
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_rd = v.rd; ID_use_rs1 = v.u1; ID_use_rs2 = v.u2;
    ID_rs1_data = v.d1; ID_rs2_data = v.d2; ID_imm = v.imm;
    ID_RegWrite = v.rw; ID_MemRead = v.mr; ID_MemWrite = 1'b0; ID_MemtoReg = v.mr; ID_ALUSrc = v.mr;
    ID_Branch = 1'b0; ID_Jump = 1'b0; ID_ALUOp = 4'h3;
    MEM_WB_RegWrite = v.mwb_rw; MEM_WB_rd = v.mwb_rd; WB_data = v.wb;
    EX_flush = v.exf; INT_flush = v.intf; hold = v.hold;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d.stall", idx), load_use_stall, v.e_stall);
    chk($sformatf("v%0d.pc_write", idx), PC_write, v.e_pcw);
    chk($sformatf("v%0d.ifid_write", idx), IF_ID_write, v.e_pcw);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.valid", idx), ID_EX_valid, v.e_valid);
    chk($sformatf("v%0d.rd", idx), ID_EX_rd, v.e_rd);
    chk($sformatf("v%0d.rs1", idx), ID_EX_rs1, v.e_rs1);
    chk($sformatf("v%0d.rs1_data", idx), ID_EX_rs1_data, v.e_d1);
    chk($sformatf("v%0d.rs2_data", idx), ID_EX_rs2_data, v.e_d2);
    chk($sformatf("v%0d.imm", idx), ID_EX_imm, v.e_imm);
    chk($sformatf("v%0d.memread", idx), ID_EX_MemRead, v.e_mr);
    chk($sformatf("v%0d.memtoreg", idx), ID_EX_MemtoReg, v.e_mr);
    chk($sformatf("v%0d.regwrite", idx), ID_EX_RegWrite, v.e_rw);
    chk($sformatf("v%0d.stall_cnt", idx), stall_cnt, v.e_cnt);
  endtask

  task automatic rand_inputs();
    IF_ID_valid = 1'($urandom); ID_pc = $urandom; ID_rs1 = 5'($urandom); ID_rs2 = 5'($urandom);
    ID_rd = 5'($urandom); ID_use_rs1 = 1'($urandom); ID_use_rs2 = 1'($urandom);
    ID_rs1_data = $urandom; ID_rs2_data = $urandom; ID_imm = $urandom;
    ID_RegWrite = 1'($urandom); ID_MemRead = 1'($urandom); ID_MemWrite = 1'($urandom);
    ID_MemtoReg = 1'($urandom); ID_ALUSrc = 1'($urandom); ID_Branch = 1'($urandom);
    ID_Jump = 1'($urandom); ID_ALUOp = 4'($urandom); MEM_WB_RegWrite = 1'($urandom);
    MEM_WB_rd = 5'($urandom); WB_data = $urandom; EX_flush = 1'($urandom); INT_flush = 1'($urandom);
    hold = 1'b0;
  endtask

  initial begin
    vec_t lw5, add6;
    // ifv rs1 u1 rs2 u2 rd  d1 d2 imm  rw mr  mwb_rw mwb_rd wb  exf intf hold | stall pcw valid rd rs1 d1 d2 imm mr rw cnt
    vecs[0]  = mk(1,2,1,0,0,5, 'h100,0,4, 1,1, 0,0,0, 0,0,0,  0,1, 1,5,2,'h100,0,4,1,1,0);
    vecs[1]  = mk(1,5,1,3,1,6, 'h11,'h33,0, 1,0, 0,0,0, 0,0,0,  1,0, 0,0,0,0,0,0,0,0,1);
    vecs[2]  = mk(1,5,1,3,1,6, 'h11,'h33,0, 1,0, 1,5,'hCAFE0005, 0,0,0,  0,1, 1,6,5,'hCAFE0005,'h33,0,0,1,1);
    vecs[3]  = mk(1,1,1,0,0,5, 'h200,0,8, 1,1, 0,0,0, 0,0,0,  0,1, 1,5,1,'h200,0,8,1,1,1);
    vecs[4]  = mk(1,5,0,0,0,5, 'h55,0,'h12345000, 1,0, 0,0,0, 0,0,0,  0,1, 1,5,5,'h55,0,'h12345000,0,1,1);
    vecs[5]  = mk(1,4,1,0,0,7, 'h300,0,0, 1,1, 0,0,0, 0,0,0,  0,1, 1,7,4,'h300,0,0,1,1,1);
    vecs[6]  = mk(1,8,1,7,1,0, 'h88,0,0, 0,0, 0,0,0, 0,0,0,  1,0, 0,0,0,0,0,0,0,0,2);
    vecs[7]  = mk(1,8,1,7,1,0, 'h88,0,0, 0,0, 1,7,'hDEADBEEF, 0,0,0,  0,1, 1,0,8,'h88,'hDEADBEEF,0,0,0,2);
    vecs[8]  = mk(1,0,1,0,1,9, 0,0,0, 1,0, 1,0,'hDEADBEEF, 0,0,0,  0,1, 1,9,0,0,0,0,0,1,2);
    vecs[9]  = mk(1,7,1,7,0,10, 'h77,'h70,0, 1,1, 0,7,'hDEADBEEF, 0,0,0,  0,1, 1,10,7,'h77,'h70,0,1,1,2);
    vecs[10] = mk(1,10,1,0,0,11, 1,0,0, 1,0, 0,0,0, 1,0,0,  0,1, 0,0,0,0,0,0,0,0,2);
    vecs[11] = mk(1,7,1,0,0,10, 'h77,0,0, 1,1, 0,0,0, 0,0,0,  0,1, 1,10,7,'h77,0,0,1,1,2);
    vecs[12] = mk(1,10,1,0,0,11, 1,0,0, 1,0, 0,0,0, 0,1,0,  0,1, 0,0,0,0,0,0,0,0,2);
    vecs[13] = mk(0,3,1,0,0,12, 'h12,0,0, 1,1, 0,0,0, 0,0,0,  0,1, 0,0,3,'h12,0,0,0,0,2);
    vecs[14] = mk(1,2,1,0,0,5, 'h100,0,4, 1,1, 0,0,0, 0,0,0,  0,1, 1,5,2,'h100,0,4,1,1,2);
    vecs[15] = mk(0,5,1,0,0,6, 'h9,0,0, 1,0, 0,0,0, 0,0,0,  0,1, 0,0,5,'h9,0,0,0,0,2);
    vecs[16] = mk(1,1,1,0,0,0, 1,0,0, 1,1, 0,0,0, 0,0,0,  0,1, 1,0,1,1,0,0,1,1,2);
    vecs[17] = mk(1,0,1,0,0,3, 0,0,0, 1,0, 0,0,0, 0,0,0,  0,1, 1,3,0,0,0,0,0,1,2);
    vecs[18] = mk(1,2,1,0,0,5, 'h100,0,4, 1,1, 0,0,0, 0,0,0,  0,1, 1,5,2,'h100,0,4,1,1,2);
    vecs[19] = mk(1,5,1,0,0,6, 'h11,0,0, 1,0, 0,0,0, 0,0,1,  1,0, 1,5,2,'h100,0,4,1,1,2);
    vecs[20] = mk(1,5,1,0,0,6, 'h11,0,0, 1,0, 0,0,0, 0,0,1,  1,0, 1,5,2,'h100,0,4,1,1,2);
    vecs[21] = mk(1,5,1,0,0,6, 'h11,0,0, 1,0, 0,0,0, 0,0,1,  1,0, 1,5,2,'h100,0,4,1,1,2);
    vecs[22] = mk(1,5,1,0,0,6, 'h11,0,0, 1,0, 0,0,0, 0,0,0,  1,0, 0,0,0,0,0,0,0,0,3);
    vecs[23] = mk(1,5,1,0,0,6, 'h11,0,0, 1,0, 1,5,'hCAFE0005, 0,0,0,  0,1, 1,6,5,'hCAFE0005,0,0,0,1,3);
    vecs[24] = mk(1,7,1,0,0,10, 'h77,0,0, 1,1, 0,0,0, 0,0,1,  0,0, 1,6,5,'hCAFE0005,0,0,0,1,3);
    vecs[25] = mk(1,7,1,0,0,10, 'h77,0,0, 1,1, 0,0,0, 0,0,0,  0,1, 1,10,7,'h77,0,0,1,1,3);
    vecs[26] = mk(1,10,1,0,0,11, 1,0,0, 1,0, 0,0,0, 1,0,1,  0,0, 0,0,0,0,0,0,0,0,3);

    // Reset with random inputs on the ID side.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rand_inputs();
      @(posedge clk);
      #1;
      chk("rst.valid", ID_EX_valid, 1'b0);
      chk("rst.pc", ID_EX_pc, 32'h0);
      chk("rst.rd", ID_EX_rd, 5'd0);
      chk("rst.rs1_data", ID_EX_rs1_data, 32'h0);
      chk("rst.imm", ID_EX_imm, 32'h0);
      chk("rst.ctrl", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                       ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump}, 7'h0);
      chk("rst.aluop", ID_EX_ALUOp, 4'h0);
      chk("rst.stall_cnt", stall_cnt, 16'h0);
      chk("rst.pc_write", PC_write, 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) run_vec(i, vecs[i]);

    // Saturation: repeated load/dependent pairs, narrow copy must pin at 7.
    lw5  = vecs[0];
    add6 = vecs[1];
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(lw5);
      @(posedge clk);
      @(negedge clk);
      drive(add6);
      #1;
      chk($sformatf("sat%0d.stall", k), load_use_stall, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.cnt", k), stall_cnt, 16'(3 + k));
      chk($sformatf("sat%0d.cnt_narrow", k), s_cnt, (3 + k > 7) ? 3'd7 : 3'(3 + k));
    end

    // Reset while a load-use stall is pending.
    @(negedge clk);
    drive(lw5);
    @(posedge clk);
    @(negedge clk);
    drive(add6);
    #1;
    chk("rststall.stall_before", load_use_stall, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rststall.valid", ID_EX_valid, 1'b0);
    chk("rststall.memread", ID_EX_MemRead, 1'b0);
    chk("rststall.cnt", stall_cnt, 16'h0);
    chk("rststall.cnt_narrow", s_cnt, 3'd0);
    chk("rststall.stall", load_use_stall, 1'b0);
    chk("rststall.pc_write", PC_write, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
